// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: receive side of a scanned 7-segment display bus.
// The segment lines and one-hot digit strobes are synchronized and filtered.
// Each stable pattern is decoded back to BCD and captured per digit position.
// Every completed frame is offered on a valid/ready output.
//
// Output handshake: frame_valid rises when a frame loads. While it is high,
// frame_data and frame_err hold steady. The frame is taken in any cycle in
// which frame_valid and frame_ready are both high. frame_valid then falls on
// the next edge, unless a new frame loads on that same edge. frame_ready is
// ignored while frame_valid is low. If a frame completes while the output is
// still occupied, that frame is dropped and overrun pulses for one cycle.
module seg7_scan_decoder #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  input  logic [N_DIG-1:0]     dig_sel,
  output logic [4*N_DIG-1:0]   frame_data,
  output logic [N_DIG-1:0]     frame_err,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 overrun
);

  localparam int SW = N_DIG + 7;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

  // Capture FSM state; kept as a named register so checkers can bind to it
  state_t                r_state;

  logic [SW-1:0]         r_sync1;
  logic [SW-1:0]         r_sync2;
  logic [SW-1:0]         r_prev;
  logic [CW-1:0]         r_cnt;
  logic [4*N_DIG-1:0]    r_shadow_data;
  logic [N_DIG-1:0]      r_shadow_err;
  logic [N_DIG-1:0]      r_seen;
  logic [4*N_DIG-1:0]    r_frame_data;
  logic [N_DIG-1:0]      r_frame_err;
  logic                  r_frame_valid;
  logic                  r_overrun;

  logic [N_DIG-1:0]      w_dig;
  logic [6:0]            w_seg;
  logic                  w_changed;
  logic                  w_onehot;
  logic [IW-1:0]         w_idx;
  logic [4:0]            w_dec;
  logic                  w_capture;
  logic                  w_seen_full;
  logic                  w_out_free;

  // Map a segment pattern {a..g} back to {err, bcd}.
  // A blank pattern decodes to F. Anything unknown decodes to E with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = {1'b0, 4'h0};
      7'h30:   r = {1'b0, 4'h1};
      7'h6D:   r = {1'b0, 4'h2};
      7'h79:   r = {1'b0, 4'h3};
      7'h33:   r = {1'b0, 4'h4};
      7'h5B:   r = {1'b0, 4'h5};
      7'h5F:   r = {1'b0, 4'h6};
      7'h70:   r = {1'b0, 4'h7};
      7'h7F:   r = {1'b0, 4'h8};
      7'h7B:   r = {1'b0, 4'h9};
      7'h00:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  assign w_dig       = r_sync2[SW-1:7];
  assign w_seg       = r_sync2[6:0];
  assign w_changed   = (r_sync2 != r_prev);
  assign w_onehot    = ($countones(w_dig) == 1);
  assign w_dec       = decode(w_seg);
  assign w_seen_full = &r_seen;
  assign w_out_free  = !r_frame_valid || frame_ready;
  assign w_capture   = (r_state == ST_SETTLE) && !w_changed &&
                       (r_cnt == CW'(STABLE_CYC - 1));

  // Index of the active strobe; only meaningful when the strobe is one-hot
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (w_dig[i]) w_idx = IW'(i);
    end
  end

  // Two-flop synchronizer for the whole bus, plus a copy of last cycle's sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {dig_sel, seg_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Stability counter: restarts on any change of the sample, saturates at STABLE_CYC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_changed) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(STABLE_CYC)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture FSM: wait for a stable one-hot strobe, then latch the digit once per change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shadow_data <= '0;
      r_shadow_err  <= '0;
      r_seen        <= '0;
    end else begin
      // A completed frame is handed off on this edge, so start collecting afresh
      if (w_seen_full) r_seen <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_onehot) r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_capture) begin
            r_shadow_data[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
            r_shadow_err[w_idx]                <= w_dec[4];
            r_seen[w_idx]                      <= 1'b1;
            r_state                            <= ST_CAPTURED;
          end else if (w_changed) begin
            r_state <= w_onehot ? ST_SETTLE : ST_IDLE;
          end
        end
        ST_CAPTURED: begin
          if (w_changed) r_state <= w_onehot ? ST_SETTLE : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load a completed frame when free, otherwise flag the drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data  <= '0;
      r_frame_err   <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_seen_full && w_out_free) begin
        r_frame_data  <= r_shadow_data;
        r_frame_err   <= r_shadow_err;
        r_frame_valid <= 1'b1;
      end else begin
        if (w_seen_full) r_overrun <= 1'b1;
        if (r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_err   = r_frame_err;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (N_DIG=4, STABLE_CYC=4).
// It uses a table of full frames plus hand-written sequences.
// The hand-written sequences cover glitches, backpressure, simultaneous
// ready/completion, and reset in the middle of a frame.
module tb_seg7_scan_decoder;
  localparam int N_DIG      = 4;
  localparam int STABLE_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        frame_ready = 1'b1;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int overrun_cnt = 0;

  // expected accepted frames: {err[3:0], data[15:0]}
  logic [19:0] exp_q[$];

  typedef struct {
    logic [27:0] segs;   // digit i pattern at [7i+6:7i]
    logic [15:0] data;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[6];

  // clock
  always #5 clk = ~clk;

  seg7_scan_decoder #(.N_DIG(N_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .frame_data (frame_data),
    .frame_err  (frame_err),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard: compare each accepted frame against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) valid_cycles++;
      if (overrun) overrun_cnt++;
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got data %h err %b, expected no frame", frame_data, frame_err);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("frame_data", {16'h0, frame_data}, {16'h0, e[15:0]});
          check("frame_err", {28'h0, frame_err}, {28'h0, e[19:16]});
        end
      end
    end
  end

  // advance n clocks, landing 2 time units after the rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int idx, input logic [6:0] seg, input int hold);
    dig_sel = '0;
    dig_sel[idx] = 1'b1;
    seg_in = seg;
    step(hold);
  endtask

  task automatic idle(input int n);
    dig_sel = '0;
    seg_in = '0;
    step(n);
  endtask

  task automatic scan_frame(input logic [27:0] segs);
    for (int i = 0; i < N_DIG; i++) begin
      drive(i, segs[7*i +: 7], $urandom_range(STABLE_CYC + 8, STABLE_CYC + 3));
    end
  endtask

  initial begin
    vecs[0] = '{segs: {7'h5F, 7'h5B, 7'h33, 7'h79}, data: 16'h6543, err: 4'b0000};
    vecs[1] = '{segs: {7'h7B, 7'h7E, 7'h1F, 7'h00}, data: 16'h90EF, err: 4'b0010};
    vecs[2] = '{segs: {7'h79, 7'h6D, 7'h30, 7'h7E}, data: 16'h3210, err: 4'b0000};
    vecs[3] = '{segs: {7'h7F, 7'h70, 7'h5F, 7'h5B}, data: 16'h8765, err: 4'b0000};
    vecs[4] = '{segs: {7'h30, 7'h73, 7'h00, 7'h7B}, data: 16'h1EF9, err: 4'b0100};
    vecs[5] = '{segs: {7'h33, 7'h40, 7'h7E, 7'h70}, data: 16'h4E07, err: 4'b0100};

    // reset
    step(3);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_data", {16'h0, frame_data}, 32'h0);
    check("rst_err", {28'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    step(3);

    // table of full frames, consumer always ready
    frame_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      valid_cycles = 0;
      exp_q.push_back({vecs[v].err, vecs[v].data});
      scan_frame(vecs[v].segs);
      idle(12);
      check("vec_frame_seen", exp_q.size(), 32'h0);
      check("vec_valid_1cyc", valid_cycles, 32'd1);
      check("vec_valid_low", {31'h0, frame_valid}, 32'h0);
    end
    check("vec_no_overrun", overrun_cnt, 32'h0);

    // short pattern on digit 1 must be rejected in favour of the held one
    valid_cycles = 0;
    exp_q.push_back({4'b0000, 16'h3210});
    drive(0, 7'h7E, 10);
    drive(1, 7'h7F, 3);
    drive(1, 7'h30, 10);
    drive(2, 7'h6D, 10);
    drive(3, 7'h79, 10);
    idle(12);
    check("glitch_seg_frame", exp_q.size(), 32'h0);
    check("glitch_seg_valid", valid_cycles, 32'd1);

    // multi-hot strobe must capture nothing; digit 1 left out to expose it
    valid_cycles = 0;
    dig_sel = 4'b0011;
    seg_in = 7'h7F;
    step(10);
    drive(0, 7'h7E, 10);
    drive(2, 7'h6D, 10);
    drive(3, 7'h79, 10);
    idle(12);
    check("glitch_strobe_none", valid_cycles, 32'd0);
    exp_q.push_back({4'b0000, 16'h3210});
    drive(1, 7'h30, 10);
    idle(12);
    check("glitch_strobe_frame", exp_q.size(), 32'h0);
    check("glitch_strobe_valid", valid_cycles, 32'd1);

    // backpressure: frame A held, frame B dropped with one overrun pulse
    frame_ready = 1'b0;
    overrun_cnt = 0;
    exp_q.push_back({4'b0000, 16'h1234});
    scan_frame({7'h30, 7'h6D, 7'h79, 7'h33});
    idle(5);
    check("bp_a_valid", {31'h0, frame_valid}, 32'h1);
    check("bp_a_data", {16'h0, frame_data}, 32'h1234);
    scan_frame({7'h7F, 7'h70, 7'h5F, 7'h5B});
    idle(12);
    check("bp_overrun_cnt", overrun_cnt, 32'd1);
    check("bp_hold_data", {16'h0, frame_data}, 32'h1234);
    check("bp_hold_valid", {31'h0, frame_valid}, 32'h1);
    frame_ready = 1'b1;
    step(1);
    check("bp_ready_drop", {31'h0, frame_valid}, 32'h0);
    check("bp_consumed", exp_q.size(), 32'h0);

    // ready on exactly the cycle frame C completes: valid stays, C loads
    frame_ready = 1'b0;
    overrun_cnt = 0;
    exp_q.push_back({4'b0000, 16'h7890});
    scan_frame({7'h70, 7'h7F, 7'h7B, 7'h7E});
    idle(5);
    check("sim_d_valid", {31'h0, frame_valid}, 32'h1);
    exp_q.push_back({4'b0000, 16'h2468});
    drive(0, 7'h7F, 10);
    drive(1, 7'h5F, 10);
    drive(2, 7'h33, 10);
    // digit 3 is captured on the 7th edge after driving; completion follows
    drive(3, 7'h6D, 7);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    check("sim_valid_stays", {31'h0, frame_valid}, 32'h1);
    check("sim_data_c", {16'h0, frame_data}, 32'h2468);
    check("sim_no_overrun", overrun_cnt, 32'h0);
    check("sim_d_consumed", exp_q.size(), 32'd1);
    step(3);
    idle(3);
    frame_ready = 1'b1;
    step(2);
    check("sim_c_consumed", exp_q.size(), 32'h0);
    check("sim_valid_low", {31'h0, frame_valid}, 32'h0);

    // reset mid-frame with a held frame pending
    frame_ready = 1'b0;
    scan_frame({7'h7E, 7'h33, 7'h30, 7'h40});
    idle(3);
    check("rm_pre_valid", {31'h0, frame_valid}, 32'h1);
    drive(0, 7'h5B, 10);
    drive(1, 7'h5F, 10);
    drive(2, 7'h70, 10);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("rm_valid", {31'h0, frame_valid}, 32'h0);
    check("rm_data", {16'h0, frame_data}, 32'h0);
    check("rm_err", {28'h0, frame_err}, 32'h0);
    check("rm_overrun", {31'h0, overrun}, 32'h0);
    dig_sel = '0;
    seg_in = '0;
    step(2);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    step(2);
    valid_cycles = 0;
    drive(3, 7'h30, 10);
    idle(12);
    check("rm_partial_none", valid_cycles, 32'd0);
    exp_q.push_back({4'b0000, 16'h1765});
    drive(0, 7'h5B, 10);
    drive(1, 7'h5F, 10);
    drive(2, 7'h70, 10);
    idle(12);
    check("rm_frame", exp_q.size(), 32'h0);
    check("rm_valid_1cyc", valid_cycles, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display path: it watches a multiplexed, scanned display bus of segment lines plus one-hot digit strobes and recovers the BCD digit values.
- It synchronizes and filters the bus, decodes each stable segment pattern back to BCD, and collects one value per digit position.
- Each complete frame is presented on a valid/ready output handshake.
- Used for display loopback checking and for reading display-driving peripherals.

Parameters:
- N_DIG, 4, number of scanned digit positions (≥1).
- STABLE_CYC, 4, consecutive identical synchronized samples required before capture (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines {a,b,c,d,e,f,g}, active-high, a = MSB; asynchronous to clk.
- dig_sel  input  N_DIG  digit strobes, active-high, one-hot when valid; asynchronous to clk.
- frame_data  output  4*N_DIG  decoded BCD; digit i in bits [4i+3:4i].
- frame_err  output  N_DIG  per-digit flag: unrecognised pattern.
- frame_valid  output  1  frame_data/frame_err hold a complete frame.
- frame_ready  input  1  consumer accepts the frame when high together with frame_valid.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- **Reset:** one clock; reset is asynchronous and active-low. While rst_n = 0:
  - frame_data = 0, frame_err = 0, frame_valid = 0, overrun = 0.
  - Synchronizers, stability counter, shadow registers and seen mask all clear; FSM = IDLE.
  - A reset mid-frame discards partial captures.
- **Input conditioning:** seg_in and dig_sel pass together through a 2-flop synchronizer. All logic below uses the synchronized value S = {dig_sel_s, seg_s}.
- **Stability counter:**
  - Cleared whenever S differs from S of the previous cycle.
  - Otherwise increments, saturating at STABLE_CYC.
- **Decode (abcdefg to BCD):**
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9; err = 0.
  - 00 (blank) → 4'hF, err = 0.
  - Any other pattern, including tailless 6 (1F) and tailless 9 (73) → 4'hE, err = 1.
- **FSM states:**
  - IDLE: dig_sel_s is zero or multi-hot. Stay here; nothing is captured. Go to SETTLE when dig_sel_s is one-hot.
  - SETTLE: one-hot strobe active; wait for the counter.
    - When the counter reaches STABLE_CYC-1 with S unchanged, on that edge: shadow[idx] ← decoded value and err, seen[idx] ← 1, go to CAPTURED.
    - Any change of S before that: return to IDLE if dig_sel_s is not one-hot, else stay in SETTLE with the counter cleared.
  - CAPTURED: wait for S to change, then re-evaluate as in IDLE. The same digit is never captured twice without an intervening change.
- **Recapture:** a digit captured again before the frame completes overwrites shadow[idx]; last value wins.
- **Frame completion:** on the edge after seen becomes all-ones:
  - Output free (frame_valid = 0, or frame_valid & frame_ready in that cycle): frame_data/frame_err ← shadow, frame_valid ← 1.
  - Output occupied (frame_valid = 1 and frame_ready = 0): outputs unchanged, overrun pulses for one cycle, frame dropped.
  - In both cases seen clears to 0 on that edge.
- **Output handshake:**
  - frame_valid stays high and frame_data/frame_err stay stable until a cycle with frame_ready = 1.
  - frame_valid falls on the following edge unless a new frame loads on that same edge, in which case frame_valid stays high.
  - frame_ready while frame_valid = 0 is ignored.
- **Latency:** a strobe/pattern held at the pins for STABLE_CYC+3 or more clk cycles is always captured. One held for fewer than STABLE_CYC cycles is never captured.

Test Plan:
1. N_DIG=4, STABLE_CYC=4, frame_ready=1; scan digits 0..3 with patterns 79, 33, 5B, 5F, each held 10 cycles, strobes one-hot → frame_valid for exactly 1 cycle, frame_data = 16'h6543, frame_err = 0.
2. Glitch rejection: digit 1 strobe held with pattern 7F for 3 cycles, then pattern 30 for 10 cycles → captured nibble for digit 1 = 1, not 8. A strobe glitch on 2 hot bits for 10 cycles → no capture.
3. Decode edges: patterns 00, 1F, 7E, 7B on digits 0..3 → frame_data = 16'h90EF, frame_err = 4'b0010.
4. Backpressure: frame_ready=0; complete frame A = 16'h1234, then complete frame B → frame_data stays 16'h1234, exactly one overrun pulse. Raising frame_ready → frame_valid drops next edge.
5. Simultaneous ready and completion: frame_valid=1, frame_ready=1 on the cycle frame C completes → frame_valid stays 1, frame_data = C, no overrun.
6. Reset mid-frame: capture digits 0..2, assert rst_n=0 asynchronously between edges → all outputs 0 immediately. After release, scanning only digit 3 gives no frame_valid until all 4 digits are captured again.
